// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : 5-stage pipeline forwarding, load-use stall and flush
// control with saturating statistics counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             regwrite_d,
  input  logic             is_load_d,
  input  logic             valid_d,
  input  logic             pcsrc_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_entry_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } stage_entry_t;

  ex_entry_t    r_ex;
  stage_entry_t r_mem;
  stage_entry_t r_wb;

  logic w_lw_stall;

  // Loads in MEM/WB are tracked for completeness but never consulted.
  logic unused_is_load;
  assign unused_is_load = &{1'b0, r_mem.is_load, r_wb.is_load};

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input stage_entry_t mem,
                                         input stage_entry_t wb);
    if (mem.regwrite && (mem.rd != 5'd0) && (mem.rd == rs))
      fwd_sel = 2'b10;
    else if (wb.regwrite && (wb.rd != 5'd0) && (wb.rd == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign w_lw_stall = valid_d && r_ex.is_load && (r_ex.rd != 5'd0) &&
                      ((r_ex.rd == rs1_d) || (r_ex.rd == rs2_d));

  // A resolved branch overrides the load-use stall: the dependent is squashed.
  assign stall_f     = w_lw_stall && !pcsrc_e;
  assign stall_d     = w_lw_stall && !pcsrc_e;
  assign flush_d     = pcsrc_e;
  assign flush_e     = w_lw_stall || pcsrc_e;
  assign forward_a_e = fwd_sel(r_ex.rs1, r_mem, r_wb);
  assign forward_b_e = fwd_sel(r_ex.rs2, r_mem, r_wb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex         <= '0;
      r_mem        <= '0;
      r_wb         <= '0;
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= '{rd: r_ex.rd, regwrite: r_ex.regwrite, is_load: r_ex.is_load};
      if (flush_e || !valid_d)
        r_ex <= '0;
      else
        r_ex <= '{rd: rd_d, regwrite: regwrite_d, is_load: is_load_d,
                  rs1: rs1_d, rs2: rs2_d};
      if (stall_d && (lu_stall_cnt != {CNT_W{1'b1}}))
        lu_stall_cnt <= lu_stall_cnt + CNT_ONE;
      if (pcsrc_e && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard : directed scenarios plus randomized run against a
// stage-array reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic [4:0]       rs1_d, rs2_d, rd_d;
  logic             regwrite_d, is_load_d, valid_d, pcsrc_e;
  logic [1:0]       forward_a_e, forward_b_e;
  logic             stall_f, stall_d, flush_d, flush_e;
  logic [CNT_W-1:0] lu_stall_cnt, flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .is_load_d(is_load_d), .valid_d(valid_d),
    .pcsrc_e(pcsrc_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: st[0]=EX, st[1]=MEM, st[2]=WB, plus integer counters.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ent_t;

  ent_t st [3];
  int   m_lu;
  int   m_fl;

  function automatic bit exp_lw();
    return valid_d && st[0].ld && (st[0].rd != 0) &&
           ((st[0].rd == rs1_d) || (st[0].rd == rs2_d));
  endfunction

  // Youngest producer among MEM/WB wins; x0 is never a dependency.
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    for (int i = 1; i <= 2; i++)
      if (st[i].wr && st[i].rd == rs) return (i == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) st[i] <= '0;
      m_lu <= 0;
      m_fl <= 0;
    end else begin
      if (exp_lw() && !pcsrc_e) m_lu <= (m_lu < CNT_MAX) ? m_lu + 1 : CNT_MAX;
      if (pcsrc_e)              m_fl <= (m_fl < CNT_MAX) ? m_fl + 1 : CNT_MAX;
      st[2] <= st[1];
      st[1] <= st[0];
      if (exp_lw() || pcsrc_e || !valid_d) st[0] <= '0;
      else st[0] <= '{rd: rd_d, wr: regwrite_d, ld: is_load_d, rs1: rs1_d, rs2: rs2_d};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit wr, input bit ld, input bit br);
    valid_d = v; rd_d = rd; rs1_d = rs1; rs2_d = rs2;
    regwrite_d = wr; is_load_d = ld; pcsrc_e = br;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 5'd3, 5'd3, 5'd3, 1, 1, 1);
    tick();
    tick();
    #2;
    tests_run++;
    if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_fwd: got a=%b b=%b expected 00 00", forward_a_e, forward_b_e);
    end
    tests_run++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0011", {stall_f, stall_d, flush_d, flush_e});
    end
    tests_run++;
    if (lu_stall_cnt !== '0 || flush_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got lu=%0d fl=%0d expected 0 0", lu_stall_cnt, flush_cnt);
    end
    pcsrc_e = 1'b0;
    do_reset();
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    drive(1, 5'd5, 5'd1, 5'd2, 1, 0, 0);   // add x5
    tick();
    drive(1, 5'd6, 5'd5, 5'd0, 1, 0, 0);   // sub x6, x5
    tick();
    drive(1, 5'd8, 5'd0, 5'd5, 1, 0, 0);   // or x8, x0, x5
    #2;
    tests_run++;
    if (forward_a_e !== 2'b10) begin
      tests_failed++;
      $display("FAIL alu_fwd_a_mem: got %b expected 10", forward_a_e);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    tests_run++;
    if (forward_b_e !== 2'b01 || forward_a_e !== 2'b00) begin
      tests_failed++;
      $display("FAIL alu_fwd_b_wb: got a=%b b=%b expected 00 01", forward_a_e, forward_b_e);
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 5'd7, 5'd1, 5'd1, 1, 0, 0);
    tick();
    drive(1, 5'd7, 5'd2, 5'd2, 1, 0, 0);
    tick();
    drive(1, 5'd9, 5'd7, 5'd0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    tests_run++;
    if (forward_a_e !== 2'b10) begin
      tests_failed++;
      $display("FAIL priority_mem_over_wb: got %b expected 10", forward_a_e);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 5'd3, 5'd1, 5'd0, 1, 1, 0);   // lw x3
    tick();
    drive(1, 5'd4, 5'd2, 5'd3, 1, 0, 0);   // add x4, x2, x3
    #2;
    tests_run++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL lu_stall_on: got %b expected 1101", {stall_f, stall_d, flush_d, flush_e});
    end
    tick();
    #2;
    tests_run++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      tests_failed++;
      $display("FAIL lu_stall_one_cycle: got %b expected 000", {stall_f, stall_d, flush_e});
    end
    tests_run++;
    if (lu_stall_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL lu_cnt: got %0d expected 1", lu_stall_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    tests_run++;
    if (forward_b_e !== 2'b01) begin
      tests_failed++;
      $display("FAIL lu_fwd_b_wb: got %b expected 01", forward_b_e);
    end
  endtask

  task automatic test_x0_branch();
    do_reset();
    drive(1, 5'd0, 5'd1, 5'd0, 1, 1, 0);   // lw x0
    tick();
    drive(1, 5'd4, 5'd0, 5'd0, 1, 0, 0);
    #2;
    tests_run++;
    if (stall_d !== 1'b0 || flush_e !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_no_stall: got stall_d=%b flush_e=%b expected 0 0", stall_d, flush_e);
    end
    tick();
    drive(1, 5'd3, 5'd1, 5'd0, 1, 1, 0);   // lw x3
    #2;
    tests_run++;
    if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin
      tests_failed++;
      $display("FAIL x0_no_fwd: got a=%b b=%b expected 00 00", forward_a_e, forward_b_e);
    end
    tick();
    drive(1, 5'd4, 5'd3, 5'd0, 1, 0, 1);   // use of x3 while branch resolves
    #2;
    tests_run++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      tests_failed++;
      $display("FAIL branch_wins: got %b expected 0011", {stall_f, stall_d, flush_d, flush_e});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    tests_run++;
    if (flush_cnt !== 4'd1 || lu_stall_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL branch_cnt: got fl=%0d lu=%0d expected 1 0", flush_cnt, lu_stall_cnt);
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    drive(1, 5'd3, 5'd3, 5'd0, 1, 1, 0);   // lw x3,(x3) repeated: stalls every other cycle
    for (int i = 0; i < 28; i++) tick();
    #2;
    tests_run++;
    if (lu_stall_cnt !== 4'd14) begin
      tests_failed++;
      $display("FAIL sat_pre: got %0d expected 14", lu_stall_cnt);
    end
    for (int i = 0; i < 12; i++) tick();
    #2;
    tests_run++;
    if (lu_stall_cnt !== 4'(CNT_MAX)) begin
      tests_failed++;
      $display("FAIL sat_hold: got %0d expected %0d", lu_stall_cnt, CNT_MAX);
    end
    if (stall_d !== 1'b1) tick();
    #2;
    tests_run++;
    if (stall_d !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_stall_active: got %b expected 1", stall_d);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({lu_stall_cnt, flush_cnt} !== '0 || {forward_a_e, forward_b_e} !== 4'b0000 ||
        {stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL async_reset: got lu=%0d fl=%0d fwd=%b ctrl=%b expected all 0",
               lu_stall_cnt, flush_cnt, {forward_a_e, forward_b_e},
               {stall_f, stall_d, flush_d, flush_e});
    end
    tick();
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
      #2;
      tests_run++;
      if (forward_a_e !== exp_fwd(st[0].rs1)) begin
        tests_failed++;
        $display("FAIL rnd_fwd_a @%0d: got %b expected %b", n, forward_a_e, exp_fwd(st[0].rs1));
      end
      tests_run++;
      if (forward_b_e !== exp_fwd(st[0].rs2)) begin
        tests_failed++;
        $display("FAIL rnd_fwd_b @%0d: got %b expected %b", n, forward_b_e, exp_fwd(st[0].rs2));
      end
      tests_run++;
      if ({stall_f, stall_d} !== {2{exp_lw() && !pcsrc_e}}) begin
        tests_failed++;
        $display("FAIL rnd_stall @%0d: got %b%b expected %b", n, stall_f, stall_d,
                 exp_lw() && !pcsrc_e);
      end
      tests_run++;
      if (flush_d !== pcsrc_e || flush_e !== (exp_lw() || pcsrc_e)) begin
        tests_failed++;
        $display("FAIL rnd_flush @%0d: got %b%b expected %b%b", n, flush_d, flush_e,
                 pcsrc_e, exp_lw() || pcsrc_e);
      end
      tests_run++;
      if (int'(lu_stall_cnt) != m_lu || int'(flush_cnt) != m_fl) begin
        tests_failed++;
        $display("FAIL rnd_cnt @%0d: got lu=%0d fl=%0d expected %0d %0d", n,
                 lu_stall_cnt, flush_cnt, m_lu, m_fl);
      end
      if (n % 100 == 99) do_reset();
      else tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_back_to_back();
    test_priority();
    test_load_use();
    test_x0_branch();
    test_saturation_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports rs1_d, rs2_d, rd_d  input  5 each  Decode-stage source and destination register numbers.
REQ-005 The block SHALL have ports regwrite_d, is_load_d, valid_d  input  1 each  Decode-stage writes-register, is-load and holds-instruction flags.
REQ-006 The block SHALL have port pcsrc_e  input  1  taken branch or jump resolved in Execute.
REQ-007 The block SHALL have ports forward_a_e, forward_b_e  output  2 each  select codes for the Execute-stage 3:1 operand muxes: 00 = register file, 01 = Writeback result, 10 = Memory-stage ALU result, 11 = never driven.
REQ-008 The block SHALL have ports stall_f, stall_d, flush_d, flush_e  output  1 each  pipeline-control outputs.
REQ-009 The block SHALL have ports lu_stall_cnt, flush_cnt  output  CNT_W each  statistics counters.

Function
REQ-010 The block SHALL keep three registered stage entries, EX, MEM and WB. Each entry SHALL hold rd[4:0], regwrite and is_load. The EX entry SHALL also hold rs1 and rs2.
REQ-011 Load-use hazard: lw_stall = valid_d AND EX.is_load AND EX.rd != 0 AND (EX.rd == rs1_d OR EX.rd == rs2_d); it SHALL be computed combinationally.
REQ-012 stall_f and stall_d SHALL be driven high by lw_stall AND NOT pcsrc_e.
REQ-013 flush_d SHALL equal pcsrc_e.
REQ-014 flush_e SHALL equal lw_stall OR pcsrc_e.
REQ-015 If lw_stall and pcsrc_e are asserted in the same cycle, the branch SHALL win: stall_f = stall_d = 0, flush_d = flush_e = 1.
REQ-016 On each clk edge, EX SHALL load a bubble (regwrite = 0, is_load = 0, rd = rs1 = rs2 = 0) when flush_e = 1 or valid_d = 0. Otherwise EX SHALL load {rd_d, regwrite_d, is_load_d, rs1_d, rs2_d}.
REQ-017 On each clk edge, MEM SHALL load EX and WB SHALL load MEM, unconditionally; stalls SHALL hold only the Fetch and Decode stages.
REQ-018 forward_a_e SHALL be 10 if MEM.regwrite AND MEM.rd != 0 AND MEM.rd == EX.rs1.
REQ-019 Otherwise, forward_a_e SHALL be 01 if WB.regwrite AND WB.rd != 0 AND WB.rd == EX.rs1.
REQ-020 Otherwise, forward_a_e SHALL be 00.
REQ-021 forward_b_e SHALL follow the same rules as REQ-018 to REQ-020, using EX.rs2 in place of EX.rs1.
REQ-022 When MEM and WB both match, MEM (code 10) SHALL take priority.
REQ-023 Register x0 SHALL never cause forwarding or a stall.
REQ-024 Every output SHALL be combinational from the stage registers and the current inputs, with zero-cycle latency. Forward codes SHALL refer to the instruction currently in EX.
REQ-025 lu_stall_cnt SHALL increment by 1 on each clk edge where stall_d = 1.
REQ-026 flush_cnt SHALL increment by 1 on each clk edge where pcsrc_e = 1.
REQ-027 Both counters SHALL saturate at 2^CNT_W - 1 and never wrap.
REQ-028 A load in EX whose rd matches no Decode source SHALL cause no stall. The block SHALL insert exactly one bubble per load-use pair; after that bubble the load is in MEM, and it is serviced by WB forwarding (01) on the following cycle.

Reset
REQ-029 While reset_n = 0, all stage entries SHALL be bubbles and both counters SHALL be 0, asynchronously and regardless of clk.
REQ-030 While reset_n = 0, the outputs SHALL follow from the bubble state: forward codes 00, stall_f = stall_d = 0, flush_d = flush_e = pcsrc_e.
REQ-031 Deasserting reset_n SHALL take effect at the next clk edge. The first captured Decode instruction SHALL enter EX on that edge.
REQ-032 Asserting reset_n mid-stall SHALL immediately clear stall_f and stall_d and discard all in-flight stage entries.

Verification
REQ-033 ALU back-to-back: add x5 enters EX, then sub with rs1 = x5 follows one cycle later -> forward_a_e = 10 in sub's EX cycle; one cycle later, an instruction with rs2 = x5 gets forward_b_e = 01.
REQ-034 Priority: x7 is written by two consecutive instructions, then read by a third -> forward_a_e = 10, not 01.
REQ-035 Load-use: lw x3 is in EX while Decode holds rs2 = x3 -> stall_f = stall_d = flush_e = 1 for exactly one cycle, lu_stall_cnt goes 0 -> 1, and the dependent instruction then sees forward_b_e = 01 in EX.
REQ-036 x0 and branch: lw x0 followed by a use of x0 -> no stall and forward 00; separately, pcsrc_e = 1 with lw_stall true -> stall_f = 0, flush_d = flush_e = 1, flush_cnt increments by 1.
REQ-037 Saturation and reset: with CNT_W = 4, hold a load-use stall condition for 20 cycles -> lu_stall_cnt stops at 15; then pulse reset_n low between clk edges -> counters, forwards and stalls read 0 before the next edge.
